sm4_key_schedule: RTL

- Parametrised SM4 round-key generator and store for the SM4 encryptor datapath.
- Accepts a 128-bit user key over a valid/ready handshake and computes all 32 round keys.
- Performs a configurable number of rounds per clock.
- Holds the round keys in an internal file; the crypt core reads them by round index in encrypt order or reversed (decrypt) order.

---
 rtl/sm4_encryptor_pkg.sv | 49 ++++
 rtl/sm4_key_round.sv | 25 ++
 rtl/sm4_key_schedule.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sm4_encryptor_pkg.sv
// Shared SM4 constants and types: system parameter FK, fixed parameters CK, S-box,
// and the key-schedule FSM encoding.
package sm4_encryptor_pkg;

    localparam int turn_key_num_p = 32;

    localparam logic [127:0] key_xor_mask_p = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    // CK(i) byte j = (4i + j) * 7 mod 256, byte 0 in the most significant position
    function automatic logic [31:0][31:0] gen_key_aux();
        logic [31:0][31:0] ck;
        ck = '0;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) begin
                ck[i][31-8*j -: 8] = 8'((4 * i + j) * 7);
            end
        end
        return ck;
    endfunction

    localparam logic [31:0][31:0] key_aux_p = gen_key_aux();

    typedef enum logic [1:0] {
        eKeyIdle,
        eKeyEval,
        eKeyReady
    } key_state_e;

    // Listed in natural order, so entry 0x00 lands at index 255: look up with ~x.
    localparam logic [255:0][7:0] sm4_sbox_p = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

endpackage

// File: rtl/sm4_key_round.sv
// One combinational SM4 key-expansion round: K4 = K0 ^ T'(K1 ^ K2 ^ K3 ^ CK).
module sm4_key_round
    import sm4_encryptor_pkg::*;
(
    input  logic [31:0] i_k0,
    input  logic [31:0] i_k1,
    input  logic [31:0] i_k2,
    input  logic [31:0] i_k3,
    input  logic [31:0] i_ck,
    output logic [31:0] o_k4
);

    logic [31:0] w_a;
    logic [31:0] w_b;

    assign w_a = i_k1 ^ i_k2 ^ i_k3 ^ i_ck;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign w_b[8*g +: 8] = sm4_sbox_p[~w_a[8*g +: 8]];
    end

    // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
    assign o_k4 = i_k0 ^ w_b ^ {w_b[18:0], w_b[31:19]} ^ {w_b[8:0], w_b[31:9]};

endmodule

// File: rtl/sm4_key_schedule.sv
// SM4 round-key generator and store, rounds_per_cycle_p rounds per clock.
// Optional SM4_KEY_ZEROIZE_EN adds zeroize_i to wipe the key file and state.
module sm4_key_schedule
    import sm4_encryptor_pkg::*;
#(
    parameter int rounds_per_cycle_p = 1,
    parameter int rk_addr_width_p    = 5
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
`ifdef SM4_KEY_ZEROIZE_EN
    input  logic                       zeroize_i,
`endif
    input  logic                       key_v_i,
    input  logic [127:0]               key_i,
    output logic                       key_ready_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       keys_valid_o,
    input  logic                       decrypt_i,
    input  logic [rk_addr_width_p-1:0] rk_addr_i,
    output logic [31:0]                rk_o
);

    if (!(rounds_per_cycle_p == 1 || rounds_per_cycle_p == 2 ||
          rounds_per_cycle_p == 4 || rounds_per_cycle_p == 8) ||
        (turn_key_num_p % rounds_per_cycle_p) != 0) begin : g_bad_rpc
        $error("rounds_per_cycle_p must be 1, 2, 4 or 8");
    end
    if (rk_addr_width_p != $clog2(turn_key_num_p)) begin : g_bad_aw
        $error("rk_addr_width_p must equal clog2(turn_key_num_p)");
    end

    key_state_e                  r_state;
    key_state_e                  w_next_state;
    logic [127:0]                r_k;
    logic [5:0]                  r_cnt;
    logic [31:0][31:0]           r_rk;
    logic                        w_load;
    logic                        w_last;
    logic                        w_zeroize;
    logic [31:0]                 w_w [rounds_per_cycle_p+4];
    logic [rk_addr_width_p-1:0]  w_idx;

`ifdef SM4_KEY_ZEROIZE_EN
    assign w_zeroize = zeroize_i;
`else
    assign w_zeroize = 1'b0;
`endif

    assign w_w[0] = r_k[127:96];
    assign w_w[1] = r_k[95:64];
    assign w_w[2] = r_k[63:32];
    assign w_w[3] = r_k[31:0];

    for (genvar g = 0; g < rounds_per_cycle_p; g++) begin : g_round
        sm4_key_round u_round (
            .i_k0 (w_w[g]),
            .i_k1 (w_w[g+1]),
            .i_k2 (w_w[g+2]),
            .i_k3 (w_w[g+3]),
            .i_ck (key_aux_p[r_cnt[4:0] + 5'(g)]),
            .o_k4 (w_w[g+4])
        );
    end

    assign w_last = (r_cnt + 6'(rounds_per_cycle_p)) == 6'(turn_key_num_p);

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        done_o       = 1'b0;
        key_ready_o  = 1'b0;
        busy_o       = 1'b0;
        keys_valid_o = 1'b0;
        case (r_state)
            eKeyIdle, eKeyReady: begin
                key_ready_o  = 1'b1;
                keys_valid_o = (r_state == eKeyReady);
                if (key_v_i) begin
                    w_load       = 1'b1;
                    w_next_state = eKeyEval;
                end
            end
            eKeyEval: begin
                busy_o = 1'b1;
                if (w_last) begin
                    done_o       = 1'b1;
                    w_next_state = eKeyReady;
                end
            end
            default: w_next_state = eKeyIdle;
        endcase
        // Zeroize beats both a same-cycle key transfer and completion.
        if (w_zeroize) begin
            w_next_state = eKeyIdle;
            w_load       = 1'b0;
            done_o       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= eKeyIdle;
            r_k     <= '0;
            r_cnt   <= '0;
            r_rk    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_zeroize) begin
                r_k   <= '0;
                r_cnt <= '0;
                r_rk  <= '0;
            end else if (w_load) begin
                r_k   <= key_i ^ key_xor_mask_p;
                r_cnt <= '0;
            end else if (r_state == eKeyEval) begin
                r_k   <= {w_w[rounds_per_cycle_p], w_w[rounds_per_cycle_p+1],
                          w_w[rounds_per_cycle_p+2], w_w[rounds_per_cycle_p+3]};
                r_cnt <= r_cnt + 6'(rounds_per_cycle_p);
                for (int g = 0; g < rounds_per_cycle_p; g++) begin
                    r_rk[r_cnt[4:0] + 5'(g)] <= w_w[g+4];
                end
            end
        end
    end

    // 31 - addr in 5-bit arithmetic is the bitwise complement.
    assign w_idx = decrypt_i ? ~rk_addr_i : rk_addr_i;
    assign rk_o  = r_rk[w_idx];

endmodule
